// File: rtl/mtx_seq_pkg.sv
// mtx_seq shared types: VLIW word, operand, status, FSM states.
// Also holds the NOP encoding and the load-op classifier.
package mtx_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LD_V0 = 4'd1,
    OP_LD_V1 = 4'd2,
    OP_LD_M0 = 4'd3,
    OP_MUL   = 4'd4,
    OP_ADD   = 4'd5,
    OP_MAC   = 4'd6,
    OP_ST    = 4'd7,
    OP_RELU  = 4'd8,
    OP_MOV   = 4'd9
  } op_t;

  typedef struct packed {
    op_t op1;
    op_t op2;
    op_t op3;
    op_t op4;
  } vliw_inst_t;

  typedef logic [31:0] mv_t;

  typedef struct packed {
    logic inv;
    logic of;
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam vliw_inst_t NOP_INST = '0;
  localparam int OVF_W = 8;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  function automatic logic is_load_op(input op_t op);
    return (op == OP_LD_V0) ||
           (op == OP_LD_V1) ||
           (op == OP_LD_M0);
  endfunction

  function automatic logic word_needs_in(
    input vliw_inst_t w
  );
    return is_load_op(w.op1) ||
           is_load_op(w.op2) ||
           is_load_op(w.op3) ||
           is_load_op(w.op4);
  endfunction

endpackage

// File: rtl/mtx_seq_imem.sv
// mtx_seq program memory: sync write port, async read port.
// Not reset; contents are defined only once written.
module mtx_seq_imem
  import mtx_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  vliw_inst_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output vliw_inst_t    o_rdata
);

  vliw_inst_t r_mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mtx_seq.sv
// mtx_seq: VLIW program sequencer feeding the matrix unit.
// Issues imem[base..end] (loop_count+1) times, stalls on loads.
module mtx_seq
  import mtx_seq_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int LOOP_W     = 8,
  localparam int AW        = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  vliw_inst_t        prog_wdata,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW-1:0]     end_addr,
  input  logic [LOOP_W-1:0] loop_count,
  input  logic              in_valid,
  input  mv_t               in_data,
  output logic              in_ready,
  input  status_t           st,
  output vliw_inst_t        vliw_inst,
  output mv_t               mtx_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        ovf_cnt
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [AW-1:0]     r_pc;
  logic [AW-1:0]     r_base;
  logic [AW-1:0]     r_end;
  logic [LOOP_W-1:0] r_loop;
  logic [LOOP_W-1:0] r_pass;
  logic              r_drain;
  vliw_inst_t        r_inst;
  mv_t               r_mtx;
  logic              r_err;
  logic [OVF_W-1:0]  r_ovf;

  vliw_inst_t        w_rdata;
  logic              w_we;
  logic              w_need_in;
  logic              w_can_launch;
  logic              w_launch;
  logic              w_bad_range;
  logic              w_active;
  logic              w_abort;
  logic              w_issue;
  logic              w_last;
  logic              w_final;

  mtx_seq_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  assign w_we        = prog_we && (r_state == S_IDLE);
  assign w_need_in   = word_needs_in(w_rdata);
  assign w_bad_range = base_addr > end_addr;
  assign w_last      = r_pc == r_end;
  assign w_final     = w_last && (r_pass == r_loop);

  // next-state, strobes and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_can_launch = 1'b0;
    w_active     = 1'b0;
    w_issue      = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        w_can_launch = 1'b1;
        done = (r_state == S_DONE);
        if (start) begin
          w_state_nxt = w_bad_range ? S_ERR : S_RUN;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_active = 1'b1;
        busy     = 1'b1;
        in_ready = w_need_in && !st.inv;
        w_issue  = !st.inv &&
                   !(w_need_in && !in_valid);
        if (st.inv) begin
          w_state_nxt = S_ERR;
        end else if (w_issue && w_final) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_active = 1'b1;
        busy     = 1'b1;
        if (st.inv) begin
          w_state_nxt = S_ERR;
        end else if (r_drain) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_launch = w_can_launch && start;
  assign w_abort  = w_active && st.inv;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // issue path: word and operand to the matrix unit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst <= NOP_INST;
      r_mtx  <= '0;
    end else begin
      r_inst <= w_issue ? w_rdata : NOP_INST;
      if (w_issue && w_need_in) begin
        r_mtx <= in_data;
      end
    end
  end

  // program counter, pass counter and launch latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_base <= '0;
      r_end  <= '0;
      r_loop <= '0;
      r_pass <= '0;
    end else if (w_launch) begin
      r_pc   <= base_addr;
      r_base <= base_addr;
      r_end  <= end_addr;
      r_loop <= loop_count;
      r_pass <= '0;
    end else if (w_issue && !w_final) begin
      if (w_last) begin
        r_pc   <= r_base;
        r_pass <= r_pass + 1'b1;
      end else begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  // final word's status lands two edges after issue,
  // so DRAIN spans two status samples before DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain <= 1'b0;
    end else begin
      r_drain <= (r_state == S_DRAIN);
    end
  end

  // sticky error flag and saturating overflow count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_ovf <= '0;
    end else if (w_launch) begin
      r_err <= w_bad_range;
      r_ovf <= '0;
    end else begin
      if (w_abort) begin
        r_err <= 1'b1;
      end
      if (w_active && st.of && (r_ovf != OVF_MAX)) begin
        r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  assign vliw_inst = r_inst;
  assign mtx_in    = r_mtx;
  assign err       = r_err;
  assign ovf_cnt   = r_ovf;

endmodule

// File: tb/tb_mtx_seq.sv
// tb_mtx_seq: randomized self-checking bench for mtx_seq.
// Expected issue streams come from a flattened program model.
module tb_mtx_seq;
  import mtx_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [5:0]  prog_addr;
  vliw_inst_t  prog_wdata;
  logic        start;
  logic [5:0]  base_addr;
  logic [5:0]  end_addr;
  logic [7:0]  loop_count;
  logic        in_valid;
  mv_t         in_data;
  logic        in_ready;
  status_t     st;
  vliw_inst_t  vliw_inst;
  mv_t         mtx_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;

  vliw_inst_t mem_m [64];
  mv_t        m_mtx;

  mtx_seq #(.IMEM_DEPTH(64), .LOOP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .base_addr  (base_addr),
    .end_addr   (end_addr),
    .loop_count (loop_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .st         (st),
    .vliw_inst  (vliw_inst),
    .mtx_in     (mtx_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_ld(input vliw_inst_t w);
    bit r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      int o;
      o = int'(w[15-4*i -: 4]);
      if (o >= 1 && o <= 3) r = 1;
    end
    return r;
  endfunction

  function automatic vliw_inst_t rnd_word(input bit loads);
    vliw_inst_t w;
    w.op1 = op_t'($urandom_range(4, 9));
    if (loads) begin
      w.op2 = op_t'($urandom_range(0, 9));
      w.op3 = op_t'($urandom_range(0, 9));
      w.op4 = op_t'($urandom_range(0, 9));
    end else begin
      w.op2 = op_t'($urandom_range(4, 9));
      w.op3 = OP_NOP;
      w.op4 = op_t'($urandom_range(4, 9));
    end
    return w;
  endfunction

  task automatic write_word(input int a, input vliw_inst_t w);
    prog_we    = 1'b1;
    prog_addr  = 6'(a);
    prog_wdata = w;
    @(negedge clk);
    prog_we    = 1'b0;
    mem_m[a]   = w;
  endtask

  task automatic launch(input int b, input int e, input int l);
    start      = 1'b1;
    base_addr  = 6'(b);
    end_addr   = 6'(e);
    loop_count = 8'(l);
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (vliw_inst !== NOP_INST || mtx_in !== 32'd0 ||
        in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: inst=%h mtx=%h rdy=%b busy=%b done=%b err=%b ovf=%0d, want all zero",
               vliw_inst, mtx_in, in_ready, busy, done, err, ovf_cnt);
    end
    m_mtx = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: valid always, 1: random valid, 2: 3 low cycles on loads
  task automatic test_sequence(input string name, input int b,
                               input int e, input int l,
                               input int mode);
    vliw_inst_t seq [$];
    vliw_inst_t exp_i;
    int idx, drain, lowcnt;
    bit need, v, fin;
    seq = {};
    for (int p = 0; p <= l; p++)
      for (int a = b; a <= e; a++) seq.push_back(mem_m[a]);
    launch(b, e, l);
    exp_i = NOP_INST;
    idx = 0; drain = 0; lowcnt = 0; fin = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      checks++;
      if (vliw_inst !== exp_i || mtx_in !== m_mtx) begin
        errors++;
        $display("FAIL %s issue k=%0d: inst=%h mtx=%h, want inst=%h mtx=%h",
                 name, k, vliw_inst, mtx_in, exp_i, m_mtx);
      end
      if (idx < seq.size()) begin
        need = is_ld(seq[idx]);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== need) begin
          errors++;
          $display("FAIL %s run k=%0d: busy=%b done=%b rdy=%b, want 1 0 %b",
                   name, k, busy, done, in_ready, need);
        end
        case (mode)
          0: v = 1;
          1: v = ($urandom_range(0, 2) != 0);
          default: v = !(need && lowcnt < 3);
        endcase
        if (need && !v) lowcnt++;
        in_valid = v;
        in_data  = $urandom;
        if (need && !v) exp_i = NOP_INST;
        else begin
          exp_i = seq[idx];
          if (need) m_mtx = in_data;
          idx++;
        end
      end else if (drain < 2) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s drain k=%0d: busy=%b done=%b rdy=%b, want 1 0 0",
                   name, k, busy, done, in_ready);
        end
        in_valid = 1'b0;
        exp_i = NOP_INST;
        drain++;
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done k=%0d: done=%b busy=%b, want 1 0",
                   name, k, done, busy);
        end
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || vliw_inst !== NOP_INST || err !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%b inst=%h err=%b, want 0 0 0",
               name, done, vliw_inst, err);
    end
  endtask

  task automatic test_abort();
    vliw_inst_t w;
    for (int a = 0; a < 5; a++) write_word(a, rnd_word(0));
    launch(0, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (vliw_inst !== mem_m[k-1]) begin
        errors++;
        $display("FAIL abort pre k=%0d: inst=%h, want %h",
                 k, vliw_inst, mem_m[k-1]);
      end
    end
    st.inv = 1'b1;
    @(negedge clk);
    st.inv = 1'b0;
    checks++;
    if (vliw_inst !== NOP_INST || err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort hit: inst=%h err=%b busy=%b, want 0 1 0",
               vliw_inst, err, busy);
    end
    w = rnd_word(0);
    prog_we = 1'b1; prog_addr = 6'd0; prog_wdata = w;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      prog_we = 1'b0;
      checks++;
      if (vliw_inst !== NOP_INST || err !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL abort hold k=%0d: inst=%h err=%b rdy=%b, want 0 1 0",
                 k, vliw_inst, err, in_ready);
      end
    end
    launch(0, 4, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort relaunch: err=%b busy=%b, want 0 1", err, busy);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (vliw_inst !== (k <= 5 ? mem_m[k-1] : NOP_INST) ||
          done !== (k == 7)) begin
        errors++;
        $display("FAIL abort rerun k=%0d: inst=%h done=%b, want %h %b",
                 k, vliw_inst, done,
                 (k <= 5 ? mem_m[k-1] : NOP_INST), (k == 7));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    for (int a = 0; a < 50; a++) write_word(a, rnd_word(0));
    launch(0, 49, 5);
    st.of = 1'b1;
    for (int k = 1; k <= 302; k++) begin
      @(negedge clk);
      if (k == 100) begin
        checks++;
        if (ovf_cnt !== 8'd100) begin
          errors++;
          $display("FAIL ovf mid: ovf=%0d, want 100", ovf_cnt);
        end
      end
    end
    st.of = 1'b0;
    checks++;
    if (ovf_cnt !== 8'd255 || done !== 1'b1) begin
      errors++;
      $display("FAIL ovf sat: ovf=%0d done=%b, want 255 1", ovf_cnt, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    vliw_inst_t w;
    write_word(2, '{OP_LD_V0, OP_ADD, OP_MUL, OP_NOP});
    write_word(3, rnd_word(0));
    launch(2, 3, 2);
    in_valid = 1'b1;
    in_data  = $urandom | 32'h1;
    repeat (4) @(negedge clk);
    checks++;
    if (mtx_in !== in_data) begin
      errors++;
      $display("FAIL midrun load: mtx=%h, want %h", mtx_in, in_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (vliw_inst !== NOP_INST || mtx_in !== 32'd0 ||
        in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrun rst: inst=%h mtx=%h rdy=%b busy=%b done=%b err=%b ovf=%0d, want all zero",
               vliw_inst, mtx_in, in_ready, busy, done, err, ovf_cnt);
    end
    m_mtx = '0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    w = rnd_word(0);
    prog_we = 1'b1; prog_addr = 6'd10; prog_wdata = w;
    mem_m[10] = w;
    launch(10, 10, 0);
    prog_we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (vliw_inst !== (k == 1 ? w : NOP_INST) || done !== (k == 3)) begin
        errors++;
        $display("FAIL midrun wr+start k=%0d: inst=%h done=%b, want %h %b",
                 k, vliw_inst, done, (k == 1 ? w : NOP_INST), (k == 3));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bounds();
    launch(5, 4, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL bounds: err=%b busy=%b ovf=%0d, want 1 0 0",
               err, busy, ovf_cnt);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (vliw_inst !== NOP_INST || err !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL bounds hold k=%0d: inst=%h err=%b done=%b, want 0 1 0",
                 k, vliw_inst, err, done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; base_addr = '0; end_addr = '0; loop_count = '0;
    in_valid = 1'b0; in_data = '0; st = '0;
    test_reset();
    for (int a = 0; a < 4; a++) write_word(a, rnd_word(0));
    test_sequence("single", 0, 3, 0, 0);
    test_sequence("loop", 2, 3, 2, 0);
    write_word(0, '{OP_LD_M0, OP_ADD, OP_NOP, OP_NOP});
    test_sequence("stall", 0, 1, 0, 2);
    for (int a = 16; a < 32; a++) write_word(a, rnd_word(1));
    for (int i = 0; i < 4; i++) begin
      int b, e;
      b = $urandom_range(16, 31);
      e = $urandom_range(b, 31);
      test_sequence("random", b, e, $urandom_range(0, 2), 1);
    end
    test_abort();
    test_overflow();
    test_reset_midrun();
    test_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
